adap_sped_ctl: RTL and testbench



---
 rtl/adap_sped_ctl.sv | 135 +++++++++++++
 tb/tb_adap_sped_ctl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/adap_sped_ctl.sv
// G.726 adaptation speed control: FUNCTF, FILTA/B/C, SUBTC, TRIGA and LIMA for 16/24/32/40 kbit/s.
// Latency: AL is a combinational function of the stored AP; inputs reach AL after one CLK edge.
// Backpressure: none; every edge consumes one sample (optional CE hold when ADAP_SPED_CTL_CE_EN is defined).
module adap_sped_ctl (
  input  logic        CLK,
  input  logic        reset,
`ifdef ADAP_SPED_CTL_CE_EN
  input  logic        CE,
`endif
  input  logic [4:0]  I,
  input  logic [1:0]  RATE,
  input  logic        TDP,
  input  logic [12:0] Y,
  input  logic        TR,
  output logic [6:0]  AL
);

  logic [11:0] dms_q, dms_d;
  logic [13:0] dml_q, dml_d;
  logic [9:0]  ap_q,  ap_d;

  logic [2:0]  f;
  logic [12:0] fa_dif;
  logic [11:0] dmsp;
  logic [14:0] fb_dif;
  logic [13:0] dmlp;
  logic [14:0] dif;
  logic [14:0] difm_w;
  logic [13:0] difm;
  logic [13:0] dthr;
  logic        ax;
  logic [10:0] fc_dif;
  logic [9:0]  app;
  logic [9:0]  apr;
  logic        upd_en;
  logic        unused_bits;

`ifdef ADAP_SPED_CTL_CE_EN
  assign upd_en = CE;
`else
  assign upd_en = 1'b1;
`endif

  // FUNCTF: rate-dependent weight; only the LSBs that belong to the active rate index the table
  always_comb begin
    f = 3'd0;
    case (RATE)
      2'b11: begin
        case (I[1:0])
          2'd1, 2'd2: f = 3'd7;
          default:    f = 3'd0;
        endcase
      end
      2'b10: begin
        case (I[2:0])
          3'd1, 3'd6: f = 3'd1;
          3'd2, 3'd5: f = 3'd2;
          3'd3, 3'd4: f = 3'd7;
          default:    f = 3'd0;
        endcase
      end
      2'b01: begin
        case (I[3:0])
          4'd3, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: f = 3'd1;
          4'd6, 4'd9:                            f = 3'd3;
          4'd7, 4'd8:                            f = 3'd7;
          default:                               f = 3'd0;
        endcase
      end
      default: begin
        case (I)
          5'd5, 5'd6, 5'd7, 5'd8, 5'd9:      f = 3'd1;
          5'd10:                             f = 3'd2;
          5'd11:                             f = 3'd3;
          5'd12:                             f = 3'd4;
          5'd13:                             f = 3'd5;
          5'd14, 5'd15, 5'd16, 5'd17:        f = 3'd6;
          5'd18:                             f = 3'd5;
          5'd19:                             f = 3'd4;
          5'd20:                             f = 3'd3;
          5'd21:                             f = 3'd2;
          5'd22, 5'd23, 5'd24, 5'd25, 5'd26: f = 3'd1;
          default:                           f = 3'd0;
        endcase
      end
    endcase
  end

  // Filters, speed-control decision and next-state selection; shifts are explicit sign extensions
  always_comb begin
    // FILTA: short-term average, gain 2^-5
    fa_dif = {1'b0, f, 9'd0} - {1'b0, dms_q};
    dmsp   = dms_q + {{4{fa_dif[12]}}, fa_dif[12:5]};
    // FILTB: long-term average, gain 2^-7
    fb_dif = {1'b0, f, 11'd0} - {1'b0, dml_q};
    dmlp   = dml_q + {{6{fb_dif[14]}}, fb_dif[14:7]};
    // SUBTC: AX=0 only for a stationary, non-tonal signal at a large enough scale factor
    dif    = {1'b0, dmsp, 2'b00} - {1'b0, dmlp};
    difm_w = dif[14] ? (15'd0 - dif) : dif;
    difm   = difm_w[13:0];
    dthr   = {3'b000, dmlp[13:3]};
    ax     = ~((Y >= 13'd1536) && (difm < dthr) && !TDP);
    // FILTC: speed-control state, gain 2^-4
    fc_dif = {1'b0, ax, 9'd0} - {1'b0, ap_q};
    app    = ap_q + {{3{fc_dif[10]}}, fc_dif[10:4]};
    // TRIGA: a transition forces fast adaptation
    apr    = TR ? 10'd256 : app;
    // State advances only when enabled; otherwise hold
    dms_d  = upd_en ? dmsp : dms_q;
    dml_d  = upd_en ? dmlp : dml_q;
    ap_d   = upd_en ? apr  : ap_q;
  end

  // Low-order bits shifted out by the filters are intentionally discarded
  assign unused_bits = ^{fa_dif[4:0], fb_dif[6:0], fc_dif[3:0], difm_w[14]};

  // State registers with synchronous reset that overrides enable and TR
  always_ff @(posedge CLK) begin
    if (reset) begin
      dms_q <= 12'd0;
      dml_q <= 14'd0;
      ap_q  <= 10'd0;
    end else begin
      dms_q <= dms_d;
      dml_q <= dml_d;
      ap_q  <= ap_d;
    end
  end

  // LIMA: limit the stored speed-control state
  always_comb begin
    AL = (ap_q >= 10'd256) ? 7'd64 : {1'b0, ap_q[7:2]};
  end

endmodule

// File: tb/tb_adap_sped_ctl.sv
// Directed bench for adap_sped_ctl: table of per-edge vectors plus multi-cycle sequences.
// Latency: checks outputs 1 time unit after each rising edge, and AL just before the edge.
// Backpressure: none; one sample per edge.
module tb_adap_sped_ctl;

  logic        CLK;
  logic        reset;
  logic [4:0]  I;
  logic [1:0]  RATE;
  logic        TDP;
  logic [12:0] Y;
  logic        TR;
  logic [6:0]  AL;
`ifdef ADAP_SPED_CTL_CE_EN
  logic        CE;
`endif

  int checks = 0;
  int errors = 0;

  adap_sped_ctl dut (
    .CLK   (CLK),
    .reset (reset),
`ifdef ADAP_SPED_CTL_CE_EN
    .CE    (CE),
`endif
    .I     (I),
    .RATE  (RATE),
    .TDP   (TDP),
    .Y     (Y),
    .TR    (TR),
    .AL    (AL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [1:0]  rate;
    logic [4:0]  i;
    logic        tdp;
    logic [12:0] y;
    logic        tr;
    logic [6:0]  al;
    logic [11:0] dms;
    logic [13:0] dml;
    logic [9:0]  ap;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] rate, input logic [4:0] i,
                       input logic tdp, input logic [12:0] y, input logic tr);
    reset = rst;
    RATE  = rate;
    I     = i;
    TDP   = tdp;
    Y     = y;
    TR    = tr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string name, input int al, input int dms, input int dml, input int ap);
    chk({name, ".al"},  int'(AL),        al);
    chk({name, ".dms"}, int'(dut.dms_q), dms);
    chk({name, ".dml"}, int'(dut.dml_q), dml);
    chk({name, ".ap"},  int'(dut.ap_q),  ap);
  endtask

  // Reset, force AP=256 with TR, then run a stationary input for 2000 samples
  task automatic decay(input string name, input logic tdp, input logic [12:0] y,
                       input int exp_al, input int exp_ap);
    drive(1'b1, 2'b01, 5'd3, tdp, y, 1'b0);
    tick();
    drive(1'b0, 2'b01, 5'd3, tdp, y, 1'b1);
    tick();
    chk({name, ".tr_ap"}, int'(dut.ap_q), 256);
    TR = 1'b0;
    for (int k = 0; k < 2000; k++) tick();
    chk_state(name, exp_al, 481, 1921, exp_ap);
  endtask

  initial begin
    int bad;
    logic [6:0] prev_al;

    drive(1'b1, 2'b00, 5'd0, 1'b0, 13'd0, 1'b0);
`ifdef ADAP_SPED_CTL_CE_EN
    CE = 1'b1;
`endif
    //            rst   rate   i       tdp   y         tr      al     dms      dml      ap
    vecs[0]  = '{1'b1, 2'b11, 5'd1,  1'b0, 13'd0,    1'b1,  7'd0,  12'd0,   14'd0,   10'd0};
    vecs[1]  = '{1'b0, 2'b11, 5'd1,  1'b0, 13'd0,    1'b0,  7'd8,  12'd112, 14'd112, 10'd32};
    vecs[2]  = '{1'b1, 2'b00, 5'd0,  1'b0, 13'd0,    1'b0,  7'd0,  12'd0,   14'd0,   10'd0};
    vecs[3]  = '{1'b0, 2'b00, 5'd15, 1'b0, 13'd0,    1'b0,  7'd8,  12'd96,  14'd96,  10'd32};
    vecs[4]  = '{1'b1, 2'b00, 5'd0,  1'b0, 13'd0,    1'b0,  7'd0,  12'd0,   14'd0,   10'd0};
    vecs[5]  = '{1'b0, 2'b00, 5'd16, 1'b0, 13'd0,    1'b0,  7'd8,  12'd96,  14'd96,  10'd32};
    vecs[6]  = '{1'b0, 2'b00, 5'd16, 1'b0, 13'd0,    1'b0,  7'd15, 12'd189, 14'd191, 10'd62};
    vecs[7]  = '{1'b0, 2'b10, 5'd3,  1'b0, 13'd0,    1'b1,  7'd64, 12'd295, 14'd301, 10'd256};
    vecs[8]  = '{1'b0, 2'b11, 5'd29, 1'b0, 13'd0,    1'b0,  7'd64, 12'd397, 14'd410, 10'd272};
    vecs[9]  = '{1'b0, 2'b01, 5'd16, 1'b0, 13'd0,    1'b0,  7'd64, 12'd384, 14'd406, 10'd287};
    vecs[10] = '{1'b1, 2'b01, 5'd7,  1'b1, 13'd4000, 1'b1,  7'd0,  12'd0,   14'd0,   10'd0};
    vecs[11] = '{1'b0, 2'b01, 5'd7,  1'b1, 13'd4000, 1'b0,  7'd8,  12'd112, 14'd112, 10'd32};
    vecs[12] = '{1'b0, 2'b01, 5'd9,  1'b1, 13'd4000, 1'b0,  7'd15, 12'd156, 14'd159, 10'd62};
    vecs[13] = '{1'b0, 2'b10, 5'd5,  1'b0, 13'd0,    1'b0,  7'd22, 12'd183, 14'd189, 10'd90};

    tick();
    prev_al = 7'd0;
    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].rst, vecs[v].rate, vecs[v].i, vecs[v].tdp, vecs[v].y, vecs[v].tr);
      #1;
      if (v > 0) chk($sformatf("vec%0d.pre_edge_al", v), int'(AL), int'(prev_al));
      tick();
      chk_state($sformatf("vec%0d", v), int'(vecs[v].al), int'(vecs[v].dms),
                int'(vecs[v].dml), int'(vecs[v].ap));
      prev_al = vecs[v].al;
    end

`ifdef ADAP_SPED_CTL_CE_EN
    // Hold with CE=0 while other inputs would otherwise change the state
    CE = 1'b0;
    drive(1'b0, 2'b11, 5'd1, 1'b0, 13'd0, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    chk_state("ce_hold", 22, 183, 189, 90);
    reset = 1'b1;
    tick();
    chk_state("ce_reset", 0, 0, 0, 0);
    CE = 1'b1;
`endif

    // Transition then AX=1 forever: AL pinned at 64, AP climbs to 497
    drive(1'b0, 2'b01, 5'd7, 1'b0, 13'd0, 1'b1);
    tick();
    chk("tr.al", int'(AL), 64);
    chk("tr.ap", int'(dut.ap_q), 256);
    TR = 1'b0;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (AL != 7'd64) bad++;
    end
    chk("tr.al_not_64_count", bad, 0);
    chk("tr.ap_settle", int'(dut.ap_q), 497);

    // Stationary decay and its two blocked variants
    decay("decay",     1'b0, 13'd1536, 0,  0);
    decay("decay_tdp", 1'b1, 13'd1536, 64, 497);
    decay("decay_y",   1'b0, 13'd1535, 64, 497);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
